// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths and ALU operand-select encodings
package cpu_pkg;
    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam logic ASEL_RS1 = 1'b0;
    localparam logic ASEL_PC  = 1'b1;
    localparam logic BSEL_IMM = 1'b0;
    localparam logic BSEL_RS2 = 1'b1;
endpackage

// File: rtl/fwd_pick.sv
// fwd_pick: priority forwarding select for one register operand (index 0 youngest)
module fwd_pick #(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int REGW = cpu_pkg::REGW,
    parameter int NFWD = 2
) (
    input  logic [REGW-1:0]      rs_addr,
    input  logic [XLEN-1:0]      rs_data,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*REGW-1:0] fwd_addr,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic [NFWD-1:0]      fwd_pending,
    output logic [XLEN-1:0]      data,
    output logic                 hit,
    output logic                 pending
);
    // scan oldest to youngest so the lowest matching index overwrites last and wins
    always_comb begin
        data = rs_data;
        hit = 1'b0;
        pending = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && fwd_addr[i*REGW +: REGW] == rs_addr && rs_addr != '0) begin
                data = fwd_data[i*XLEN +: XLEN];
                hit = 1'b1;
                pending = fwd_pending[i];
            end
        end
    end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ALU operand select with forwarding, load-use interlock and output register
// Forwarding and hazard logic are built only when ALU_OPSEL_FWD_EN is defined.
module alu_operand_stage import cpu_pkg::*; #(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int REGW = cpu_pkg::REGW,
    parameter int NFWD = 2,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REGW-1:0]      rs1_addr,
    input  logic [REGW-1:0]      rs2_addr,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
    input  logic [XLEN-1:0]      pc,
    input  logic [XLEN-1:0]      ext_imm,
    input  logic                 a_sel,
    input  logic                 b_sel,
    input  logic                 is_store,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*REGW-1:0] fwd_addr,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic [NFWD-1:0]      fwd_pending,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      din_1,
    output logic [XLEN-1:0]      din_2,
    output logic [XLEN-1:0]      store_data,
    output logic                 hazard,
    output logic [CNTW-1:0]      hazard_cnt
);
    logic [XLEN-1:0] op1, op2;
    logic            hit1, hit2, pend1, pend2;
    logic            use1, use2, accept;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] din_1_q, din_1_d, din_2_q, din_2_d, store_data_q, store_data_d;
    logic [CNTW-1:0] hazard_cnt_q, hazard_cnt_d;

`ifdef ALU_OPSEL_FWD_EN
    fwd_pick #(.XLEN(XLEN), .REGW(REGW), .NFWD(NFWD)) u_pick1 (
        .rs_addr(rs1_addr), .rs_data(rs1_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .fwd_pending(fwd_pending), .data(op1), .hit(hit1), .pending(pend1)
    );
    fwd_pick #(.XLEN(XLEN), .REGW(REGW), .NFWD(NFWD)) u_pick2 (
        .rs_addr(rs2_addr), .rs_data(rs2_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .fwd_pending(fwd_pending), .data(op2), .hit(hit2), .pending(pend2)
    );
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_valid, fwd_addr, fwd_data, fwd_pending};
    assign op1 = rs1_data;
    assign op2 = rs2_data;
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
    assign pend1 = 1'b0;
    assign pend2 = 1'b0;
`endif

    // handshake, interlock and next-state for the operand register and hazard counter
    always_comb begin
        use1 = a_sel == ASEL_RS1;
        use2 = b_sel == BSEL_RS2 || is_store;
        hazard = in_valid && ((use1 && hit1 && pend1) || (use2 && hit2 && pend2));
        in_ready = (!out_valid_q || out_ready) && !hazard;
        accept = in_valid && in_ready && !flush;
        out_valid_d = flush ? 1'b0 : accept ? 1'b1 : (out_valid_q && out_ready) ? 1'b0 : out_valid_q;
        din_1_d = accept ? (a_sel == ASEL_PC ? pc : op1) : din_1_q;
        din_2_d = accept ? (b_sel == BSEL_RS2 ? op2 : ext_imm) : din_2_q;
        store_data_d = accept ? op2 : store_data_q;
        hazard_cnt_d = (hazard && hazard_cnt_q != '1) ? hazard_cnt_q + 1'b1 : hazard_cnt_q;
    end

    // state registers; reset drops any in-flight instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            din_1_q <= '0;
            din_2_q <= '0;
            store_data_q <= '0;
            hazard_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            din_1_q <= din_1_d;
            din_2_q <= din_2_d;
            store_data_q <= store_data_d;
            hazard_cnt_q <= hazard_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign din_1 = din_1_q;
    assign din_2 = din_2_q;
    assign store_data = store_data_q;
    assign hazard_cnt = hazard_cnt_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed table-driven bench for alu_operand_stage
module tb_alu_operand_stage;
`ifdef ALU_OPSEL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0;
    logic [31:0] rs1_data = '0, rs2_data = '0, pc = '0, ext_imm = '0;
    logic        a_sel = 1'b0, b_sel = 1'b0, is_store = 1'b0;
    logic [1:0]  fwd_valid = '0, fwd_pending = '0;
    logic [9:0]  fwd_addr = '0;
    logic [63:0] fwd_data = '0;
    logic        flush = 1'b0, out_valid, out_ready = 1'b1;
    logic [31:0] din_1, din_2, store_data;
    logic        hazard;
    logic [15:0] hazard_cnt;
    int checks = 0, errors = 0;

    alu_operand_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .pc(pc), .ext_imm(ext_imm), .a_sel(a_sel), .b_sel(b_sel), .is_store(is_store),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_pending(fwd_pending),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .din_1(din_1), .din_2(din_2), .store_data(store_data),
        .hazard(hazard), .hazard_cnt(hazard_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r1, r2;
        logic        a, b, st;
        logic [1:0]  fv;
        logic [4:0]  fa0, fa1;
        logic [31:0] fd0, fd1;
        logic [31:0] x1, x2, xs;
        logic [31:0] f1, f2, fs;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{3, 4, 0, 1, 0, 2'b00, 0, 0, 0, 0, 5, 9, 9, 5, 9, 9};
        vecs[1] = '{3, 4, 0, 0, 0, 2'b00, 0, 0, 0, 0, 5, 'h10, 9, 5, 'h10, 9};
        vecs[2] = '{3, 4, 1, 0, 0, 2'b00, 0, 0, 0, 0, 'h100, 'h10, 9, 'h100, 'h10, 9};
        vecs[3] = '{3, 4, 0, 1, 0, 2'b11, 3, 3, 'hAA, 'hBB, 5, 9, 9, 'hAA, 9, 9};
        vecs[4] = '{3, 4, 0, 1, 0, 2'b10, 3, 3, 'hAA, 'hBB, 5, 9, 9, 'hBB, 9, 9};
        vecs[5] = '{0, 4, 0, 1, 0, 2'b11, 0, 0, 'hAA, 'hBB, 5, 9, 9, 5, 9, 9};
        vecs[6] = '{3, 4, 0, 1, 0, 2'b01, 4, 7, 'hAA, 'hBB, 5, 9, 9, 5, 'hAA, 'hAA};
        vecs[7] = '{3, 4, 0, 0, 0, 2'b01, 4, 7, 'hAA, 'hBB, 5, 'h10, 9, 5, 'h10, 'hAA};

        step(); step();
        rst = 1'b0;
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_din_1", din_1, 0);
        chk("rst_din_2", din_2, 0);
        chk("rst_store_data", store_data, 0);
        chk("rst_hazard_cnt", {16'b0, hazard_cnt}, 0);

        rs1_data = 5; rs2_data = 9; ext_imm = 'h10; pc = 'h100; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rs1_addr = vecs[i].r1; rs2_addr = vecs[i].r2;
            a_sel = vecs[i].a; b_sel = vecs[i].b; is_store = vecs[i].st;
            fwd_valid = vecs[i].fv; fwd_addr = {vecs[i].fa1, vecs[i].fa0};
            fwd_data = {vecs[i].fd1, vecs[i].fd0};
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 1);
            step();
            chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, 1);
            chk($sformatf("v%0d_din_1", i), din_1, FWD ? vecs[i].f1 : vecs[i].x1);
            chk($sformatf("v%0d_din_2", i), din_2, FWD ? vecs[i].f2 : vecs[i].x2);
            chk($sformatf("v%0d_store_data", i), store_data, FWD ? vecs[i].fs : vecs[i].xs);
        end

        rs2_addr = 4; a_sel = 1'b1; b_sel = 1'b0; is_store = 1'b1;
        fwd_valid = 2'b11; fwd_addr = {5'd4, 5'd4}; fwd_data = {32'hEE, 32'h55}; fwd_pending = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("haz%0d_hazard", i), {31'b0, hazard}, {31'b0, FWD});
            chk($sformatf("haz%0d_in_ready", i), {31'b0, in_ready}, {31'b0, !FWD});
            step();
        end
        chk("haz_cnt3", {16'b0, hazard_cnt}, FWD ? 3 : 0);
        fwd_pending = 2'b00; fwd_data = {32'hEE, 32'h77};
        #1;
        chk("haz_release_in_ready", {31'b0, in_ready}, 1);
        step();
        chk("haz_cap_valid", {31'b0, out_valid}, 1);
        chk("haz_cap_din_1", din_1, 'h100);
        chk("haz_cap_din_2", din_2, 'h10);
        chk("haz_cap_store", store_data, FWD ? 'h77 : 9);
        chk("haz_cnt_hold", {16'b0, hazard_cnt}, FWD ? 3 : 0);

        fwd_valid = 2'b00;
        rs1_addr = 3; rs1_data = 'h1234; rs2_data = 'h5678; a_sel = 1'b0; b_sel = 1'b1; is_store = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("stall%0d_in_ready", i), {31'b0, in_ready}, 0);
            step();
            chk($sformatf("stall%0d_valid", i), {31'b0, out_valid}, 1);
            chk($sformatf("stall%0d_din_1", i), din_1, 'h100);
            chk($sformatf("stall%0d_store", i), store_data, FWD ? 'h77 : 9);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", {31'b0, in_ready}, 1);
        step();
        chk("unstall_din_1", din_1, 'h1234);
        chk("unstall_din_2", din_2, 'h5678);
        chk("unstall_store", store_data, 'h5678);

        flush = 1'b1; rs1_data = 'hDEAD; out_ready = 1'b0;
        step();
        flush = 1'b0;
        chk("flush_valid", {31'b0, out_valid}, 0);
        chk("flush_din_1", din_1, 'h1234);

        rs1_data = 'h99;
        step();
        chk("pre_rst_valid", {31'b0, out_valid}, 1);
        chk("pre_rst_din_1", din_1, 'h99);
        fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd3}; fwd_pending = 2'b01;
        step(); step();
        chk("pre_rst_cnt", {16'b0, hazard_cnt}, FWD ? 5 : 0);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", {31'b0, out_valid}, 0);
        chk("mid_rst_din_1", din_1, 0);
        chk("mid_rst_din_2", din_2, 0);
        chk("mid_rst_store", store_data, 0);
        chk("mid_rst_cnt", {16'b0, hazard_cnt}, 0);
        rst = 1'b0; in_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
